branch_comparator: RTL and testbench
====================================

# branch_comparator

Branch comparator for the RV32I execute stage. Compares the two register-file operands rs1/rs2 and produces equal and less-than flags (signed or unsigned per `brun`) combinationally for the control unit's PC-select logic. It also resolves a branch-taken decision from funct3 and offers a registered copy of all results for the next pipeline stage.

## Interface
Parameters:
- `WIDTH`, 32, operand width in bits.

Ports:
- `clk` input 1: clock. Registered outputs update on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low. One clock; asynchronous, active-low reset.
- `rs1` input WIDTH: operand A.
- `rs2` input WIDTH: operand B.
- `brun` input 1: 1 = unsigned compare, 0 = signed (two's complement) compare.
- `is_branch` input 1: current instruction is a conditional branch.
- `funct3` input 3: branch type. 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- `en` input 1: register-stage load enable.
- `breq` output 1: rs1 == rs2, combinational.
- `brlt` output 1: rs1 < rs2 under `brun`, combinational.
- `taken` output 1: branch-taken decision, combinational.
- `breq_q`, `brlt_q`, `taken_q` output 1 each: registered copies.

## Operation
- `breq` = 1 iff all WIDTH bits are equal. It is independent of `brun`.
- When `brun`=0, `brlt` uses a signed compare. Implement it as: sign bits differ → `brlt` = rs1[MSB]; otherwise `brlt` = unsigned compare of the low bits.
- When `brun`=1, `brlt` is a plain unsigned magnitude compare.
- `brlt` and `breq` are never both 1.
- `taken` is 0 when `is_branch`=0. Otherwise it is decoded from funct3:
  - BEQ → `breq`
  - BNE → !`breq`
  - BLT, BLTU → `brlt`
  - BGE, BGEU → !`brlt`
  - 010 and 011 (illegal) → 0
- `taken` uses the externally supplied `brun`. `brun` is not re-derived from funct3; the control unit keeps them consistent.
- Registered stage: on a rising edge with `en`=1, load `breq`, `brlt` and `taken` into the `_q` outputs. When `en`=0, the `_q` outputs hold.
- Boundary conditions:
  - rs1 = 0x8000_0000, rs2 = 0x7FFF_FFFF: signed `brlt`=1, unsigned `brlt`=0.
  - rs1 = rs2 = 0xFFFF_FFFF: `breq`=1, `brlt`=0 in both modes.

## Timing
- `breq`, `brlt` and `taken` have zero-cycle latency. They are purely combinational from rs1, rs2, `brun`, `funct3` and `is_branch`, and are unaffected by `rst_n`. They must settle within half a clock period.
- `_q` outputs have 1-cycle latency.
- Reset (asynchronous assert, release synchronous to `clk`): `breq_q`=0, `brlt_q`=0, `taken_q`=0. Reset asserted mid-operation clears the `_q` outputs immediately. Combinational outputs keep tracking their inputs.
- If reset and `en` are active on the same edge, reset wins.

## Structure
- Shared package: funct3 branch encodings (BEQ/BNE/BLT/BGE/BLTU/BGEU) and the default WIDTH.
- One sub-module: `magnitude_cmp` (WIDTH-bit eq/unsigned-lt). The top adds sign handling, funct3 decode and the register stage.

## Test plan
- rs1=0x10, rs2=0x12, `brun`=0 → `brlt`=1, `breq`=0; set `brun`=1 → `brlt`=1.
- rs1=-10 (0xFFFF_FFF6), rs2=10, `brun`=0 → `brlt`=1; set `brun`=1 → `brlt`=0; `breq`=0 in both modes.
- rs1=rs2=-10 in both `brun` modes → `breq`=1, `brlt`=0.
- `is_branch`=1, rs1=5, rs2=5, sweep funct3:
  - BEQ → `taken`=1
  - BNE → `taken`=0
  - BGE → `taken`=1
  - funct3=010 → `taken`=0
  - `is_branch`=0 → `taken`=0 for every funct3.
- Registered stage: rs1=3, rs2=7, `en`=1 → one edge later `brlt_q`=1. Set `en`=0 and change rs1=7 → `brlt_q` holds 1 and `breq_q` holds 0.
- Reset: drive `rst_n`=0 between edges with `_q` outputs at 1 → all `_q` outputs go to 0 without a clock edge, while `breq`/`brlt` still follow rs1/rs2.

Source files
------------

// File: rtl/branch_comparator_pkg.sv
// Shared definitions for the RV32I branch comparator.
//   DEFAULT_WIDTH : default operand width
//   branch_f3_e   : funct3 encodings of the conditional branches
package branch_comparator_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

endpackage : branch_comparator_pkg

// File: rtl/branch_comparator_magnitude_cmp.sv
// WIDTH-bit equality and unsigned less-than comparator.
//   a_i, b_i  : operands
//   eq_c_o    : a_i == b_i (combinational)
//   ltu_c_o   : a_i <  b_i unsigned (combinational)
module magnitude_cmp
  import branch_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_c_o,
  output logic             ltu_c_o
);

  assign eq_c_o  = (a_i == b_i);
  assign ltu_c_o = (a_i < b_i);

endmodule : magnitude_cmp

// File: rtl/branch_comparator.sv
// Branch comparator: eq / lt flags and branch-taken decision for the
// execute stage, plus an enable-gated registered copy for the next stage.
//   clk, rst_n            : clock, async active-low reset
//   rs1, rs2              : operands
//   brun                  : 1 = unsigned compare, 0 = signed compare
//   is_branch, funct3     : branch qualifier and type
//   en                    : load enable for the registered copies
//   breq, brlt, taken     : combinational results
//   breq_q, brlt_q, taken_q : registered results
module branch_comparator
  import branch_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             brun,
  input  logic             is_branch,
  input  logic [2:0]       funct3,
  input  logic             en,
  output logic             breq,
  output logic             brlt,
  output logic             taken,
  output logic             breq_q,
  output logic             brlt_q,
  output logic             taken_q
);

  localparam int unsigned MSB = WIDTH - 1;

  logic eq_c;
  logic ltu_c;
  logic sign_diff_c;

  logic breq_d;
  logic brlt_d;
  logic taken_d;

  // Full-width unsigned compare; reused for the signed case below.
  magnitude_cmp #(
    .WIDTH (WIDTH)
  ) u_magnitude_cmp (
    .a_i     (rs1),
    .b_i     (rs2),
    .eq_c_o  (eq_c),
    .ltu_c_o (ltu_c)
  );

  // With equal sign bits the full unsigned compare equals the low-bit
  // compare, so only the differing-sign case needs special handling.
  assign sign_diff_c = rs1[MSB] ^ rs2[MSB];

  assign breq = eq_c;
  assign brlt = (!brun && sign_diff_c) ? rs1[MSB] : ltu_c;

  // funct3 decode; illegal encodings and non-branches never take.
  always_comb begin
    taken = 1'b0;
    if (is_branch) begin
      case (funct3)
        F3_BEQ:          taken = breq;
        F3_BNE:          taken = !breq;
        F3_BLT, F3_BLTU: taken = brlt;
        F3_BGE, F3_BGEU: taken = !brlt;
        default:         taken = 1'b0;
      endcase
    end
  end

  // Next-state for the register stage: load on en, otherwise hold.
  always_comb begin
    breq_d  = breq_q;
    brlt_d  = brlt_q;
    taken_d = taken_q;
    if (en) begin
      breq_d  = breq;
      brlt_d  = brlt;
      taken_d = taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      breq_q  <= 1'b0;
      brlt_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      breq_q  <= breq_d;
      brlt_q  <= brlt_d;
      taken_q <= taken_d;
    end
  end

endmodule : branch_comparator

// File: tb/tb_branch_comparator.sv
// Self-checking bench for branch_comparator: directed vector table,
// hand-written register/reset sequences and randomized checks against a
// behavioural model.
module tb_branch_comparator;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         brun;
  logic         is_branch;
  logic [2:0]   funct3;
  logic         en;
  logic         breq;
  logic         brlt;
  logic         taken;
  logic         breq_q;
  logic         brlt_q;
  logic         taken_q;

  int checks = 0;
  int errors = 0;

  branch_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1       (rs1),
    .rs2       (rs2),
    .brun      (brun),
    .is_branch (is_branch),
    .funct3    (funct3),
    .en        (en),
    .breq      (breq),
    .brlt      (brlt),
    .taken     (taken),
    .breq_q    (breq_q),
    .brlt_q    (brlt_q),
    .taken_q   (taken_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         un;
    logic         isb;
    logic [2:0]   f3;
    logic         x_eq;
    logic         x_lt;
    logic         x_tk;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (rs1=%h rs2=%h brun=%b isb=%b f3=%b) t=%0t",
               name, act, exp, rs1, rs2, brun, is_branch, funct3, $time);
    end
  endtask

  // Reference model from the architectural definition of the compares.
  function automatic logic m_lt(input logic [W-1:0] a, input logic [W-1:0] b, input logic un);
    if (un) return (a < b);
    return ($signed(a) < $signed(b));
  endfunction

  function automatic logic m_taken(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic un, input logic isb, input logic [2:0] f3);
    logic eq;
    logic lt;
    eq = (a == b);
    lt = m_lt(a, b, un);
    if (!isb) return 1'b0;
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic un,
                       input logic isb, input logic [2:0] f3);
    rs1 = a; rs2 = b; brun = un; is_branch = isb; funct3 = f3;
  endtask

  logic e_eq_q, e_lt_q, e_tk_q;

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    drive('0, '0, 1'b0, 1'b0, 3'd0);

    // Reset state, including an edge with en=1 while reset is held.
    en = 1'b1;
    @(posedge clk); #1;
    check("rst_breq_q", breq_q, 1'b0);
    check("rst_brlt_q", brlt_q, 1'b0);
    check("rst_taken_q", taken_q, 1'b0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;

    // Directed vector table.
    vecs.push_back('{32'h10, 32'h12, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h10, 32'h12, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFF_FFF6, 32'hA, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{32'hFFFF_FFF6, 32'hA, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h5, 32'h5, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'h5, 32'h5, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h5, 32'h5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'h5, 32'h5, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h5, 32'h5, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h5, 32'h5, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h5, 32'h6, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0});
    for (int f = 0; f < 8; f++)
      vecs.push_back('{32'h5, 32'h5, 1'b0, 1'b0, 3'(f), 1'b1, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].un, vecs[i].isb, vecs[i].f3);
      #1;
      check("vec_breq", breq, vecs[i].x_eq);
      check("vec_brlt", brlt, vecs[i].x_lt);
      check("vec_taken", taken, vecs[i].x_tk);
    end

    // Register stage: load, then hold with en=0 while inputs change.
    @(negedge clk);
    drive(32'd3, 32'd7, 1'b0, 1'b1, 3'd4);
    en = 1'b1;
    @(posedge clk); #1;
    check("load_breq_q", breq_q, 1'b0);
    check("load_brlt_q", brlt_q, 1'b1);
    check("load_taken_q", taken_q, 1'b1);
    @(negedge clk);
    en = 1'b0;
    rs1 = 32'd7;
    #1;
    check("hold_comb_breq", breq, 1'b1);
    @(posedge clk); #1;
    check("hold_brlt_q", brlt_q, 1'b1);
    check("hold_breq_q", breq_q, 1'b0);
    check("hold_taken_q", taken_q, 1'b1);

    // Asynchronous reset between edges; combinational path keeps tracking.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_brlt_q", brlt_q, 1'b0);
    check("async_taken_q", taken_q, 1'b0);
    check("async_breq_q", breq_q, 1'b0);
    check("async_comb_breq", breq, 1'b1);
    rs1 = 32'd2;
    #1;
    check("async_comb_brlt", brlt, 1'b1);
    check("async_comb_breq2", breq, 1'b0);
    en = 1'b1;
    @(posedge clk); #1;
    check("rst_wins_brlt_q", brlt_q, 1'b0);
    check("rst_wins_taken_q", taken_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    // Randomized checks against the model, including the register stage.
    e_eq_q = 1'b0; e_lt_q = 1'b0; e_tk_q = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] a, b;
      logic un, isb, le;
      logic [2:0] f3;
      @(negedge clk);
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        2:       b = a + W'($urandom_range(0, 2)) - 32'd1;
        default: b = W'($urandom);
      endcase
      un  = 1'($urandom);
      isb = ($urandom_range(0, 3) != 0);
      f3  = 3'($urandom);
      le  = 1'($urandom);
      drive(a, b, un, isb, f3);
      en = le;
      #1;
      check("rnd_breq", breq, (a == b));
      check("rnd_brlt", brlt, m_lt(a, b, un));
      check("rnd_taken", taken, m_taken(a, b, un, isb, f3));
      if (le) begin
        e_eq_q = (a == b);
        e_lt_q = m_lt(a, b, un);
        e_tk_q = m_taken(a, b, un, isb, f3);
      end
      @(posedge clk); #1;
      check("rnd_breq_q", breq_q, e_eq_q);
      check("rnd_brlt_q", brlt_q, e_lt_q);
      check("rnd_taken_q", taken_q, e_tk_q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_branch_comparator
